// File: rtl/arrow_sprite_renderer.sv
// Arrow sprite renderer: frame-latched sprite shadow, 2-stage pixel hit pipeline
// and a frame-counted hit-flash FSM.
module arrow_sprite_renderer #(
    parameter int SIZE         = 40,
    parameter int FLASH_FRAMES = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 VS,
    input  logic [9:0]           DrawX,
    input  logic [9:0]           DrawY,
    input  logic [9:0]           dropX,
    input  logic [9:0]           dropY,
    input  logic [SIZE*SIZE-1:0] arrow,
    input  logic                 score,
    output logic                 arrow_on,
    output logic                 flash_on
);

    localparam int               NPIX       = SIZE * SIZE;
    localparam logic [1:0]       IDLE       = 2'd0;
    localparam logic [1:0]       FLASH      = 2'd1;
    localparam logic [1:0]       HOLD       = 2'd2;
    localparam logic [3:0]       FLASH_LOAD = 4'(FLASH_FRAMES);
    localparam logic signed [10:0] SIZE_S   = 11'(SIZE);

    // Reset asserts asynchronously but releases on a Clk edge for every flop.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_n      = rst_sync_q[1];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) rst_sync_q <= '0;
        else        rst_sync_q <= rst_sync_d;
    end

    logic              vs_q, score_q;
    logic [9:0]        sh_x_q, sh_x_d, sh_y_q, sh_y_d;
    logic [NPIX-1:0]   sh_bitmap_q, sh_bitmap_d;
    logic              inbox_q, inbox_d;
    logic [10:0]       idx_q, idx_d;
    logic              arrow_on_q, arrow_on_d;
    logic [1:0]        state_q, state_d;
    logic [3:0]        fcnt_q, fcnt_d;
    logic              flash_on_q, flash_on_d;

    logic              vs_fall, score_rise;
    logic signed [10:0] dx, dy;

    assign vs_fall    = vs_q & ~VS;
    assign score_rise = score & ~score_q;

    // Zero-extend before subtracting so a sprite near the right/bottom edge
    // cannot wrap around and hit pixels on the opposite side.
    assign dx = signed'({1'b0, DrawX}) - signed'({1'b0, sh_x_q});
    assign dy = signed'({1'b0, DrawY}) - signed'({1'b0, sh_y_q});

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        sh_x_d      = sh_x_q;
        sh_y_d      = sh_y_q;
        sh_bitmap_d = sh_bitmap_q;
        if (vs_fall) begin
            sh_x_d      = dropX;
            sh_y_d      = dropY;
            sh_bitmap_d = arrow;
        end

        inbox_d    = (dx >= 0) && (dx < SIZE_S) && (dy >= 0) && (dy < SIZE_S);
        idx_d      = inbox_d ? 11'(dy * SIZE_S + dx) : '0;
        arrow_on_d = inbox_q & sh_bitmap_q[idx_q];
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: begin
                // A coincident vs_fall is deliberately not counted here.
                if (score_rise) begin
                    fcnt_d  = FLASH_LOAD;
                    state_d = (FLASH_LOAD == 4'd0) ? HOLD : FLASH;
                end
            end
            FLASH: begin
                if (vs_fall) begin
                    if (fcnt_q <= 4'd1) begin
                        fcnt_d  = '0;
                        state_d = HOLD;
                    end else begin
                        fcnt_d = fcnt_q - 4'd1;
                    end
                end
            end
            HOLD: begin
                if (!score) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                fcnt_d  = '0;
            end
        endcase
        flash_on_d = (state_d == FLASH);
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q        <= 1'b1;
            score_q     <= 1'b0;
            sh_x_q      <= '0;
            sh_y_q      <= '0;
            // NOTE: the shadow bitmap is a wide register, not a RAM, and it must
            // be cleared so nothing is drawn between reset and the first frame.
            sh_bitmap_q <= '0;
            inbox_q     <= 1'b0;
            idx_q       <= '0;
            arrow_on_q  <= 1'b0;
            state_q     <= IDLE;
            fcnt_q      <= '0;
            flash_on_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            vs_q        <= VS;
            score_q     <= score;
            sh_x_q      <= sh_x_d;
            sh_y_q      <= sh_y_d;
            sh_bitmap_q <= sh_bitmap_d;
            inbox_q     <= inbox_d;
            idx_q       <= idx_d;
            arrow_on_q  <= arrow_on_d;
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            flash_on_q  <= flash_on_d;
        end
    end

    assign arrow_on = arrow_on_q;
    assign flash_on = flash_on_q;

endmodule

// File: tb/tb_arrow_sprite_renderer.sv
// Directed bench for arrow_sprite_renderer: latch/latency, tearing, edge
// clipping, flash sequencing and asynchronous reset.
module tb_arrow_sprite_renderer;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          VS;
    logic [9:0]    DrawX, DrawY, dropX, dropY;
    logic [1599:0] arrow;
    logic          score;
    logic          arrow_on, flash_on;

    int n_cmp = 0;
    int n_err = 0;

    arrow_sprite_renderer #(.SIZE(40), .FLASH_FRAMES(8)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .VS       (VS),
        .DrawX    (DrawX),
        .DrawY    (DrawY),
        .dropX    (dropX),
        .dropY    (dropY),
        .arrow    (arrow),
        .score    (score),
        .arrow_on (arrow_on),
        .flash_on (flash_on)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic vs_pulse();
        VS = 1'b0;
        tick();
        VS = 1'b1;
        tick();
    endtask

    task automatic pix(input int x, input int y, input logic exp, input string tag);
        DrawX = 10'(x);
        DrawY = 10'(y);
        tick();
        tick();
        check(tag, 32'(arrow_on), 32'(exp));
    endtask

    initial begin
        Reset = 1'b0;
        VS    = 1'b1;
        DrawX = '0;
        DrawY = '0;
        dropX = 10'd100;
        dropY = 10'd100;
        arrow = '0;
        arrow[418] = 1'b1;
        score = 1'b0;

        #12;
        check("rst_arrow_on", 32'(arrow_on), 32'd0);
        check("rst_flash_on", 32'(flash_on), 32'd0);
        Reset = 1'b1;
        repeat (4) tick();

        // Nothing drawn before the first frame latch.
        pix(118, 110, 1'b0, "pre_vsfall");

        // Latch and exact two-cycle latency.
        vs_pulse();
        pix(0, 0, 1'b0, "lat_bg");
        DrawX = 10'd118;
        DrawY = 10'd110;
        tick();
        check("lat_cycle1", 32'(arrow_on), 32'd0);
        tick();
        check("lat_cycle2", 32'(arrow_on), 32'd1);
        pix(117, 110, 1'b0, "lat_neighbour");

        // No tearing: new dropY only takes effect at the next frame.
        dropY = 10'd200;
        repeat (3) tick();
        pix(118, 110, 1'b1, "tear_hold");
        vs_pulse();
        pix(118, 110, 1'b0, "tear_old_pos");
        pix(118, 210, 1'b1, "tear_new_pos");

        // Right-edge clipping with a full bitmap.
        dropX = 10'd1000;
        dropY = 10'd300;
        arrow = '1;
        vs_pulse();
        pix(5, 300, 1'b0, "edge_nowrap");
        pix(1010, 300, 1'b1, "edge_visible");
        pix(1023, 339, 1'b1, "edge_corner");
        pix(1040, 300, 1'b0, "edge_oob");
        pix(1010, 299, 1'b0, "edge_above");
        pix(1010, 340, 1'b0, "edge_below");

        // All-zero bitmap draws nothing.
        arrow = '0;
        vs_pulse();
        pix(1010, 300, 1'b0, "empty_bitmap");

        // Flash: eight frames, then HOLD while score stays high.
        score = 1'b1;
        tick();
        check("fl_start", 32'(flash_on), 32'd1);
        repeat (7) vs_pulse();
        check("fl_frame7", 32'(flash_on), 32'd1);
        vs_pulse();
        check("fl_frame8", 32'(flash_on), 32'd0);
        repeat (3) tick();
        check("fl_hold", 32'(flash_on), 32'd0);
        score = 1'b0;
        tick();
        score = 1'b1;
        tick();
        check("fl_restart", 32'(flash_on), 32'd1);

        // Re-rise of score during FLASH must not reload the counter.
        repeat (3) vs_pulse();
        score = 1'b0;
        tick();
        score = 1'b1;
        tick();
        repeat (4) vs_pulse();
        check("fl_norel_7", 32'(flash_on), 32'd1);
        vs_pulse();
        check("fl_norel_8", 32'(flash_on), 32'd0);
        score = 1'b0;
        repeat (2) tick();

        // Score rise coinciding with vs_fall loads the full count.
        VS    = 1'b0;
        score = 1'b1;
        tick();
        VS = 1'b1;
        tick();
        check("sim_start", 32'(flash_on), 32'd1);
        repeat (7) vs_pulse();
        check("sim_frame7", 32'(flash_on), 32'd1);
        vs_pulse();
        check("sim_frame8", 32'(flash_on), 32'd0);
        score = 1'b0;
        repeat (2) tick();

        // Asynchronous reset mid-frame and mid-flash.
        dropX = 10'd100;
        dropY = 10'd100;
        arrow = '0;
        arrow[418] = 1'b1;
        vs_pulse();
        score = 1'b1;
        tick();
        pix(118, 110, 1'b1, "ar_arrow_pre");
        check("ar_flash_pre", 32'(flash_on), 32'd1);
        #3;
        Reset = 1'b0;
        score = 1'b0;
        #1;
        check("ar_arrow_async", 32'(arrow_on), 32'd0);
        check("ar_flash_async", 32'(flash_on), 32'd0);
        #2;
        Reset = 1'b1;
        repeat (6) tick();
        check("ar_arrow_post", 32'(arrow_on), 32'd0);
        check("ar_flash_post", 32'(flash_on), 32'd0);
        vs_pulse();
        pix(118, 110, 1'b1, "ar_arrow_relatch");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/arrow_sprite_renderer.md
ARROW_SPRITE_RENDERER -- requirements
Module: arrow_sprite_renderer

Interface
REQ-001 The block SHALL have parameter SIZE, default 40, meaning sprite width and height in pixels.
REQ-002 The block SHALL have parameter FLASH_FRAMES, default 8, meaning the number of frames the hit flash is held.
REQ-003 The block SHALL have port Clk, input, 1 bit: the pixel clock, the only clock.
REQ-004 The block SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port VS, input, 1 bit: vertical sync, active-low, synchronous to Clk.
REQ-006 The block SHALL have ports DrawX and DrawY, input, 10 bits each: current pixel coordinate.
REQ-007 The block SHALL have ports dropX and dropY, input, 10 bits each: sprite top-left position from the dropper.
REQ-008 The block SHALL have port arrow, input, 1600 bits: sprite bitmap, index = row*SIZE + col, row 0 at top.
REQ-009 The block SHALL have port score, input, 1 bit: level hit flag from the dropper.
REQ-010 The block SHALL have port arrow_on, output, 1 bit: the current pipelined pixel belongs to the sprite.
REQ-011 The block SHALL have port flash_on, output, 1 bit: the hit flash is active.

Function
REQ-012 The block SHALL detect a VS falling edge via a 1-flop delayed copy: vs_fall = VS_q & ~VS.
REQ-013 On vs_fall, the block SHALL latch dropX, dropY and arrow into shadow registers; the shadows SHALL be stable for the whole frame (no tearing).
REQ-014 Pipeline stage 1 SHALL compute dx = DrawX - shX and dy = DrawY - shY at 11-bit signed width.
REQ-015 Stage 1 SHALL register inbox = (0 <= dx < SIZE) & (0 <= dy < SIZE), together with idx = dy*SIZE + dx (11 bits, max 1599).
REQ-016 Stage 2 SHALL register arrow_on = inbox_q & shBitmap[idx_q].
REQ-017 Total latency from DrawX/DrawY to arrow_on SHALL be exactly 2 Clk cycles.
REQ-018 When inbox_q = 0, idx SHALL not be used and arrow_on SHALL be 0.
REQ-019 Sprite edges near the screen boundary SHALL be handled as follows:
- the 11-bit dx/dy SHALL prevent wrap-around, so there are no false hits for shX > 984 or shY > 440;
- a sprite partially off-screen SHALL draw only its visible portion.
REQ-020 An all-zero bitmap SHALL give arrow_on = 0 everywhere; this is the dropper-finished case.
REQ-021 The flash FSM SHALL have states IDLE, FLASH and HOLD.
REQ-022 In IDLE, a score rising edge (score & ~score_q) SHALL load fcnt = FLASH_FRAMES and move to FLASH.
REQ-023 In FLASH:
- fcnt SHALL decrement by 1 on each vs_fall;
- when fcnt = 1 and vs_fall occurs, the FSM SHALL go to HOLD with fcnt = 0.
REQ-024 In HOLD, the FSM SHALL remain until score = 0, then go to IDLE.
REQ-025 Score re-rising during FLASH SHALL be ignored; fcnt SHALL not reload.
REQ-026 A score rising edge coinciding with vs_fall in IDLE SHALL load the full FLASH_FRAMES; no decrement SHALL occur that cycle.
REQ-027 flash_on SHALL be 1 iff state = FLASH, registered.
REQ-028 fcnt SHALL be 4 bits wide; a FLASH_FRAMES value of 0 SHALL go straight IDLE -> HOLD.

Reset
REQ-029 Reset = 0 SHALL immediately force the following, independent of Clk:
- arrow_on = 0 and flash_on = 0;
- shadow position = 0 and shadow bitmap = 0;
- pipeline registers = 0;
- VS_q = 1 and score_q = 0;
- state = IDLE and fcnt = 0.
REQ-030 Reset asserted mid-frame or mid-flash SHALL abort the operation; after release, nothing SHALL be drawn until the next vs_fall.
REQ-031 Reset release SHALL be synchronised so that all flops leave reset on the same Clk edge.

Verification
REQ-032 Latch/latency: dropX=100, dropY=100, arrow[418]=1, pulse VS low, then drive DrawX=118, DrawY=110 -> arrow_on=1 exactly 2 cycles later; DrawX=117 -> 0.
REQ-033 No tearing: change dropY to 200 mid-frame, then scan (118,110) -> arrow_on still 1 until the next vs_fall, and 0 after it.
REQ-034 Boundary: shX=1000, bitmap all ones, DrawX=5, DrawY=shY -> arrow_on=0; DrawX=1010 -> 1; DrawX=1040 (out of range) -> 0.
REQ-035 Flash: score rises, then 8 vs_fall pulses -> flash_on high for exactly 8 frames; score held high -> HOLD, flash_on=0; score=0, then rises again -> flash_on=1.
REQ-036 Simultaneous: score rise on the same cycle as vs_fall -> fcnt=8, and the flash lasts a full 8 frames.
REQ-037 Async reset: assert Reset=0 between clock edges while flash_on=1 and arrow_on=1 -> both 0 without a Clk edge; after release, arrow_on=0 until the first vs_fall.
